// File: rtl/xgemac_rx_pkt_reader.sv
// xgemac_rx_pkt_reader: active reader for the XGEMAC RX packet FIFO port.
// Optional packet length check is built when XGEMAC_RX_LEN_CHECK_EN is defined.
module xgemac_rx_pkt_reader #(
  parameter int DATA_WIDTH    = 64,
  parameter int MOD_WIDTH     = 3,
  parameter int FIFO_DEPTH    = 16,
  parameter int CNT_WIDTH     = 32,
  parameter int MAX_PKT_BYTES = 1518
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pkt_rx_avail,
  output logic                  pkt_rx_ren,
  input  logic                  pkt_rx_val,
  input  logic [DATA_WIDTH-1:0] pkt_rx_data,
  input  logic                  pkt_rx_sop,
  input  logic                  pkt_rx_eop,
  input  logic [MOD_WIDTH-1:0]  pkt_rx_mod,
  input  logic                  pkt_rx_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [MOD_WIDTH-1:0]  out_mod,
  output logic                  out_err,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [CNT_WIDTH-1:0]  frm_err_cnt
`ifdef XGEMAC_RX_LEN_CHECK_EN
  ,
  output logic [CNT_WIDTH-1:0]  len_err_cnt,
  output logic [15:0]           last_pkt_len
`endif
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int EW    = DATA_WIDTH + MOD_WIDTH + 3;

  typedef enum logic {IDLE, READ} state_t;

  state_t state, state_nxt;

  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [AW:0]          wptr, rptr, count;
  logic [AW+1:0]        free, need;
  logic                 empty, credit_ok, ren_q;
  logic                 pkt_open, force_err;
  logic                 drop, mid_sop, wr, rd;
  logic                 w_sop, w_err, len_bad;
  logic [MOD_WIDTH-1:0] w_mod;

  assign count     = wptr - rptr;
  assign empty     = (count == '0);
  assign free      = (AW+2)'(FIFO_DEPTH) - (AW+2)'(count);
  // A beat requested last cycle still needs a slot, and one slot stays spare.
  assign need      = (AW+2)'(2) + (AW+2)'(ren_q);
  assign credit_ok = (free >= need);

  assign drop    = pkt_rx_val & ~pkt_rx_sop & ~pkt_open;
  assign mid_sop = pkt_rx_val & pkt_rx_sop & pkt_open;
  assign wr      = pkt_rx_val & ~drop;
  assign w_sop   = pkt_rx_sop & ~pkt_open;
  assign w_mod   = pkt_rx_eop ? pkt_rx_mod : '0;
  assign w_err   = pkt_rx_eop &
                   (pkt_rx_err | force_err | mid_sop | len_bad);

  assign out_valid  = ~empty;
  assign rd         = out_valid & out_ready;
  assign pkt_rx_ren = (state == READ) & credit_ok &
                      ~(pkt_rx_val & pkt_rx_eop);

  // Show-ahead head; forced to zero while the buffer is empty.
  always_comb begin
    {out_data, out_sop, out_eop, out_mod, out_err} = '0;
    if (!empty)
      {out_data, out_sop, out_eop, out_mod, out_err} =
        mem[rptr[AW-1:0]];
  end

  // FSM state and in-flight read tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ren_q <= 1'b0;
    end else begin
      state <= state_nxt;
      ren_q <= pkt_rx_ren;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (pkt_rx_avail && credit_ok) state_nxt = READ;
      READ: if (wr && pkt_rx_eop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Buffer pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr) wptr <= wptr + (AW+1)'(1);
      if (rd) rptr <= rptr + (AW+1)'(1);
    end
  end

  // Buffer storage; slot reuse on full read+write is safe as rptr advances.
  always_ff @(posedge clk) begin
    if (wr)
      mem[wptr[AW-1:0]] <= {pkt_rx_data, w_sop, pkt_rx_eop,
                            w_mod, w_err};
  end

  // Packet-open and forced-error tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_open  <= 1'b0;
      force_err <= 1'b0;
    end else if (wr) begin
      if (pkt_rx_eop) begin
        pkt_open  <= 1'b0;
        force_err <= 1'b0;
      end else begin
        pkt_open <= 1'b1;
        if (mid_sop) force_err <= 1'b1;
      end
    end
  end

  // Saturating statistics, counted at write time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt     <= '0;
      err_cnt     <= '0;
      frm_err_cnt <= '0;
    end else begin
      if (wr && pkt_rx_eop) begin
        if (~&pkt_cnt) pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
        if (w_err && ~&err_cnt) err_cnt <= err_cnt + CNT_WIDTH'(1);
      end
      if ((drop || mid_sop) && ~&frm_err_cnt)
        frm_err_cnt <= frm_err_cnt + CNT_WIDTH'(1);
    end
  end

`ifdef XGEMAC_RX_LEN_CHECK_EN
  logic [15:0] len_q, len_sum;
  logic [16:0] beat_bytes, len_raw;

  // Running byte length including the current beat, saturating at 16 bits.
  always_comb begin
    beat_bytes = 17'(BYTES);
    if (pkt_rx_eop && pkt_rx_mod != '0) beat_bytes = 17'(pkt_rx_mod);
    len_raw = (w_sop ? 17'd0 : {1'b0, len_q}) + beat_bytes;
    len_sum = len_raw[16] ? 16'hFFFF : len_raw[15:0];
    len_bad = pkt_rx_eop &
              ((len_sum < 16'd64) ||
               ({16'd0, len_sum} > 32'(MAX_PKT_BYTES)));
  end

  // Length accumulator, last length and length-error statistic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q        <= '0;
      last_pkt_len <= '0;
      len_err_cnt  <= '0;
    end else if (wr) begin
      len_q <= pkt_rx_eop ? 16'd0 : len_sum;
      if (pkt_rx_eop) begin
        last_pkt_len <= len_sum;
        if (len_bad && ~&len_err_cnt)
          len_err_cnt <= len_err_cnt + CNT_WIDTH'(1);
      end
    end
  end
`else
  logic unused_len;
  assign len_bad    = 1'b0;
  assign unused_len = (MAX_PKT_BYTES != 0);
`endif

endmodule
